mcb_port_arbiter: RTL and testbench
===================================

Name: mcb_port_arbiter

Overview:
- Shares one Spartan-6 MCB user port (64-bit, port 0) between NREQ burst requesters.
- Each requester posts a read or write burst. The arbiter grants round-robin, streams write words into the MCB write FIFO and issues the MCB command. For reads it issues the command and routes returned words back to the granted requester.
- Sits between application logic and ddr_interface, in the MCB user-clock (c3_clk0) domain.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AW, 30, MCB byte-address width.

Ports:
- clk  in  1  MCB user clock (c3_clk0).
- reset_n  in  1  asynchronous active-low reset.
- calib_done  in  1  MCB calibration done, already synchronised.
- req_valid  in  NREQ  burst request, held until req_ack.
- req_write  in  NREQ  1=write, 0=read.
- req_addr  in  NREQ*AW  byte address per requester; bits[2:0] ignored.
- req_len  in  NREQ*6  burst length minus 1 (0..63 = 1..64 words).
- req_ack  out  NREQ  one-cycle pulse: request latched, grant begins.
- wdata  in  NREQ*64  write word per requester.
- wdata_valid  in  NREQ  write word present.
- wdata_ready  out  NREQ  arbiter accepts write word.
- rdata  out  64  read word, shared bus.
- rdata_valid  out  NREQ  one-hot qualifier for rdata.
- done  out  NREQ  one-cycle pulse at burst completion.
- mcb_cmd_en, mcb_cmd_instr[2:0], mcb_cmd_bl[5:0], mcb_cmd_byte_addr[AW-1:0]  out  MCB command port.
- mcb_cmd_full  in  1  MCB command FIFO full.
- mcb_wr_en  out  1; mcb_wr_data  out  64; mcb_wr_mask  out  8 (always 0); mcb_wr_full  in  1.
- mcb_rd_en  out  1; mcb_rd_data  in  64; mcb_rd_empty  in  1.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; round-robin pointer selects requester 0 first.
- MCB FIFOs are not flushed by this block; the system resets the MCB alongside it.
- States: IDLE -> WR_DATA -> WR_CMD -> IDLE; IDLE -> RD_CMD -> RD_DATA -> IDLE.
- IDLE:
  - Grants only when calib_done=1 and some req_valid is set.
  - Winner is the first requester with req_valid set, searching from (last_grant+1) mod NREQ.
  - Same cycle: pulse req_ack[g]; latch write, addr with [2:0] forced to 0, and len; load word counter = len.
  - Next state is WR_DATA or RD_CMD.
- WR_DATA:
  - wdata_ready[g] = ~mcb_wr_full (combinational); other ready bits 0.
  - Transfer on wdata_valid[g] & wdata_ready[g].
  - mcb_wr_en / mcb_wr_data are registered: 1-cycle latency after the transfer.
  - Decrement counter per transfer; after the transfer with counter==0, go to WR_CMD.
- WR_CMD:
  - Issue the command in the first cycle with mcb_cmd_full=0: mcb_cmd_en=1 for exactly one cycle, instr=3'b000, bl=len, byte_addr=latched addr.
  - The command cycle is at least one cycle after the last mcb_wr_en, so MCB never sees a command before its data.
  - Pulse done[g] in the same cycle; return to IDLE.
- RD_CMD: same issue rule with instr=3'b001; reload counter=len; go to RD_DATA.
- RD_DATA:
  - mcb_rd_en = ~mcb_rd_empty (combinational).
  - Each popped word appears on rdata with rdata_valid[g]=1 one cycle later (registered).
  - Requesters cannot stall read data; they must sink every word.
  - After the pop with counter==0, go to IDLE.
  - done[g] pulses together with the last rdata_valid.
- calib_done falling: no new grants; an in-flight burst completes normally.
- Simultaneous requests: only one is acked per IDLE visit; the others stay pending.
- Minimum gap: one IDLE cycle between bursts.
- A requester dropping req_valid before ack: request is withdrawn, with no side effects.

Decomposition:
- Package mcb_pkg:
  - MCB_INSTR_WR=3'b000, MCB_INSTR_RD=3'b001.
  - MCB_DW=64, MCB_MAX_BL=64.
  - State encoding typedef.
- Sub-module rr_arbiter (NREQ-wide round-robin, one-hot grant, pointer update on accept), reusable by other shared-resource blocks.

Test Plan:
- Single write, req0 addr=0x10, len=5, six wdata words 1..6 -> six mcb_wr_en pulses carrying 1..6; then one cmd_en with instr=000, bl=5, addr=0x10; done[0] pulses.
- Single read, req1 addr=0x13, len=3; MCB model returns A..D with rd_empty gaps -> cmd addr=0x10, bl=3; rdata_valid[1] four times with A..D; done[1] with the 4th.
- Both requesters valid every cycle for four bursts -> acks alternate 0,1,0,1; no mcb activity overlaps between bursts.
- mcb_wr_full held high for 5 cycles mid-write, then mcb_cmd_full high for 3 cycles -> wdata_ready low throughout the stall; no words lost or duplicated; cmd_en issued exactly once after full clears.
- calib_done=0 with req_valid=1 -> no req_ack; calib_done rises -> ack within 1 cycle.
- reset_n asserted mid read burst -> all outputs 0 immediately; after release, IDLE; the next request is acked normally.

Source files
------------

// File: rtl/mcb_pkg.sv
// Shared constants and types for blocks that drive a Spartan-6 MCB user port.
package mcb_pkg;

    // MCB command instructions
    localparam logic [2:0] MCB_INSTR_WR = 3'b000;
    localparam logic [2:0] MCB_INSTR_RD = 3'b001;

    // User-port data width and maximum burst length in words
    localparam int MCB_DW     = 64;
    localparam int MCB_MAX_BL = 64;

    // Derived widths: byte-mask bits and burst-length field
    localparam int MCB_MW  = MCB_DW / 8;
    localparam int MCB_BLW = $clog2(MCB_MAX_BL);

    // Port arbiter sequencing states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_CMD  = 3'd2,
        ST_RD_CMD  = 3'd3,
        ST_RD_DATA = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or after
// the search pointer. The pointer advances past the winner only when the
// consumer accepts the grant, so an unaccepted grant costs no fairness.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_valid
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] idx;

    // Walk the requests from the far end back to the pointer so that the
    // last hit (the one nearest the pointer) is the one that sticks.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr_q) + i) % NREQ);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    assign grant_valid = |req;

    // Pointer moves to the requester after the accepted winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (accept && grant_valid) begin
            ptr_q <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mcb_port_arbiter.sv
// Shares MCB user port 0 between NREQ burst requesters in the c3_clk0 domain.
// Writes: stream words into the MCB write FIFO, then issue the command.
// Reads: issue the command, then route returned words to the owner.
//
// Handshakes: req_valid is held until the one-cycle req_ack; a write word
// moves on a cycle where wdata_valid and wdata_ready are both high; read
// data cannot be stalled, so every rdata_valid word must be taken.
module mcb_port_arbiter
    import mcb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 30,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    calib_done,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_write,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*MCB_BLW-1:0] req_len,
    output logic [NREQ-1:0]         req_ack,
    input  logic [NREQ*MCB_DW-1:0]  wdata,
    input  logic [NREQ-1:0]         wdata_valid,
    output logic [NREQ-1:0]         wdata_ready,
    output logic [MCB_DW-1:0]       rdata,
    output logic [NREQ-1:0]         rdata_valid,
    output logic [NREQ-1:0]         done,
    output logic                    mcb_cmd_en,
    output logic [2:0]              mcb_cmd_instr,
    output logic [MCB_BLW-1:0]      mcb_cmd_bl,
    output logic [AW-1:0]           mcb_cmd_byte_addr,
    input  logic                    mcb_cmd_full,
    output logic                    mcb_wr_en,
    output logic [MCB_DW-1:0]       mcb_wr_data,
    output logic [MCB_MW-1:0]       mcb_wr_mask,
    input  logic                    mcb_wr_full,
    output logic                    mcb_rd_en,
    input  logic [MCB_DW-1:0]       mcb_rd_data,
    input  logic                    mcb_rd_empty,
    output logic [2:0]              dbg_state
);

    arb_state_t         state;

    // Latched burst description for the current owner
    logic [NREQ-1:0]    gsel_q;
    logic [IW-1:0]      gidx_q;
    logic [AW-1:0]      addr_q;
    logic [MCB_BLW-1:0] len_q;
    logic [MCB_BLW-1:0] cnt_q;

    // Registered outputs
    logic [NREQ-1:0]    ack_q;
    logic [NREQ-1:0]    rvalid_q;
    logic [NREQ-1:0]    rdone_q;
    logic [MCB_DW-1:0]  rdata_q;
    logic               wr_en_q;
    logic [MCB_DW-1:0]  wr_data_q;

    // Arbiter interface
    logic [NREQ-1:0]    grant_c;
    logic [IW-1:0]      gidx_c;
    logic               gvalid_c;
    logic               accept_c;

    // Per-cycle decisions
    logic               wr_xfer_c;
    logic               cmd_issue_c;
    logic               rd_pop_c;
    logic [AW-1:0]      addr_sel_c;
    logic [MCB_BLW-1:0] len_sel_c;
    logic [MCB_DW-1:0]  wdata_sel_c;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req_valid),
        .accept     (accept_c),
        .grant      (grant_c),
        .grant_idx  (gidx_c),
        .grant_valid(gvalid_c)
    );

    // Select the candidate's request fields and the owner's write word.
    always_comb begin
        addr_sel_c  = req_addr[int'(gidx_c) * AW +: AW];
        len_sel_c   = req_len[int'(gidx_c) * MCB_BLW +: MCB_BLW];
        wdata_sel_c = wdata[int'(gidx_q) * MCB_DW +: MCB_DW];
    end

    // A new burst is only granted from IDLE and only once the MCB is calibrated.
    assign accept_c = (state == ST_IDLE) && calib_done && gvalid_c;

    // Write words flow while the MCB write FIFO has room.
    assign wr_xfer_c = (state == ST_WR_DATA) && wdata_valid[gidx_q] && !mcb_wr_full;

    // The write command waits out the registered last data push so the MCB
    // always holds a burst's data before it sees the command.
    assign cmd_issue_c = (((state == ST_WR_CMD) && !wr_en_q) || (state == ST_RD_CMD))
                         && !mcb_cmd_full;

    assign rd_pop_c = (state == ST_RD_DATA) && !mcb_rd_empty;

    // Burst sequencer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            gsel_q    <= '0;
            gidx_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            rvalid_q  <= '0;
            rdone_q   <= '0;
            rdata_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            ack_q    <= '0;
            rvalid_q <= '0;
            rdone_q  <= '0;
            wr_en_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        gsel_q <= grant_c;
                        gidx_q <= gidx_c;
                        addr_q <= addr_sel_c & ~AW'(7);
                        len_q  <= len_sel_c;
                        cnt_q  <= len_sel_c;
                        ack_q  <= grant_c;
                        state  <= req_write[gidx_c] ? ST_WR_DATA : ST_RD_CMD;
                    end
                end
                ST_WR_DATA: begin
                    if (wr_xfer_c) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= wdata_sel_c;
                        cnt_q     <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            state <= ST_WR_CMD;
                        end
                    end
                end
                ST_WR_CMD: begin
                    if (cmd_issue_c) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RD_CMD: begin
                    if (cmd_issue_c) begin
                        cnt_q <= len_q;
                        state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rd_pop_c) begin
                        rdata_q  <= mcb_rd_data;
                        rvalid_q <= gsel_q;
                        cnt_q    <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            rdone_q <= gsel_q;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Requester-side outputs; write completion coincides with the command.
    assign req_ack     = ack_q;
    assign wdata_ready = ((state == ST_WR_DATA) && !mcb_wr_full) ? gsel_q : '0;
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign done        = rdone_q | (((state == ST_WR_CMD) && cmd_issue_c) ? gsel_q : '0);

    // MCB-side outputs
    assign mcb_cmd_en        = cmd_issue_c;
    assign mcb_cmd_instr     = (state == ST_RD_CMD) ? MCB_INSTR_RD : MCB_INSTR_WR;
    assign mcb_cmd_bl        = len_q;
    assign mcb_cmd_byte_addr = addr_q;
    assign mcb_wr_en         = wr_en_q;
    assign mcb_wr_data       = wr_data_q;
    assign mcb_wr_mask       = '0;
    assign mcb_rd_en         = rd_pop_c;

    assign dbg_state = state;

endmodule

// File: tb/tb_mcb_port_arbiter.sv
// Directed bench for mcb_port_arbiter with two requesters and a behavioural
// MCB port driven cycle by cycle from each test task.
module tb_mcb_port_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 30;

    logic                 clk;
    logic                 reset_n;
    logic                 calib_done;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_write;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*6-1:0]    req_len;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ*64-1:0]   wdata;
    logic [NREQ-1:0]      wdata_valid;
    logic [NREQ-1:0]      wdata_ready;
    logic [63:0]          rdata;
    logic [NREQ-1:0]      rdata_valid;
    logic [NREQ-1:0]      done;
    logic                 mcb_cmd_en;
    logic [2:0]           mcb_cmd_instr;
    logic [5:0]           mcb_cmd_bl;
    logic [AW-1:0]        mcb_cmd_byte_addr;
    logic                 mcb_cmd_full;
    logic                 mcb_wr_en;
    logic [63:0]          mcb_wr_data;
    logic [7:0]           mcb_wr_mask;
    logic                 mcb_wr_full;
    logic                 mcb_rd_en;
    logic [63:0]          mcb_rd_data;
    logic                 mcb_rd_empty;
    logic [2:0]           dbg_state;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mcb_q[$];

    mcb_port_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .calib_done       (calib_done),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_len          (req_len),
        .req_ack          (req_ack),
        .wdata            (wdata),
        .wdata_valid      (wdata_valid),
        .wdata_ready      (wdata_ready),
        .rdata            (rdata),
        .rdata_valid      (rdata_valid),
        .done             (done),
        .mcb_cmd_en       (mcb_cmd_en),
        .mcb_cmd_instr    (mcb_cmd_instr),
        .mcb_cmd_bl       (mcb_cmd_bl),
        .mcb_cmd_byte_addr(mcb_cmd_byte_addr),
        .mcb_cmd_full     (mcb_cmd_full),
        .mcb_wr_en        (mcb_wr_en),
        .mcb_wr_data      (mcb_wr_data),
        .mcb_wr_mask      (mcb_wr_mask),
        .mcb_wr_full      (mcb_wr_full),
        .mcb_rd_en        (mcb_rd_en),
        .mcb_rd_data      (mcb_rd_data),
        .mcb_rd_empty     (mcb_rd_empty),
        .dbg_state        (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver helpers: inputs change on the falling edge, outputs are read 1ns later.
    task automatic drive_idle();
        req_valid    = '0;
        req_write    = '0;
        req_addr     = '0;
        req_len      = '0;
        wdata        = '0;
        wdata_valid  = '0;
        mcb_cmd_full = 1'b0;
        mcb_wr_full  = 1'b0;
        mcb_rd_data  = '0;
        mcb_rd_empty = 1'b1;
    endtask

    task automatic set_req(input int r, input logic wr, input logic [AW-1:0] a, input logic [5:0] l);
        req_write[r]       = wr;
        req_addr[r*AW +: AW] = a;
        req_len[r*6 +: 6]  = l;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        calib_done = 1'b1;
        drive_idle();
        req_valid    = 2'b11;
        mcb_rd_empty = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (req_ack !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b want=00", req_ack); end
        total++; if (wdata_ready !== 2'b00) begin bad++; $display("FAIL reset_wready got=%b want=00", wdata_ready); end
        total++; if (rdata_valid !== 2'b00 || rdata !== 64'd0) begin bad++; $display("FAIL reset_rdata got=%b/%h want=00/0", rdata_valid, rdata); end
        total++; if (done !== 2'b00) begin bad++; $display("FAIL reset_done got=%b want=00", done); end
        total++; if ({mcb_cmd_en, mcb_wr_en, mcb_rd_en} !== 3'b000) begin bad++; $display("FAIL reset_mcb_en got=%b want=000", {mcb_cmd_en, mcb_wr_en, mcb_rd_en}); end
        total++; if (mcb_cmd_byte_addr !== '0 || mcb_cmd_bl !== 6'd0 || mcb_cmd_instr !== 3'd0) begin bad++; $display("FAIL reset_cmd_fields got=%h/%0d/%b want=0/0/000", mcb_cmd_byte_addr, mcb_cmd_bl, mcb_cmd_instr); end
        total++; if (mcb_wr_mask !== 8'h00 || mcb_wr_data !== 64'd0) begin bad++; $display("FAIL reset_wr_fields got=%h/%h want=00/0", mcb_wr_mask, mcb_wr_data); end
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
        drive_idle();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_write();
        int idx = 0, acks = 0, wrs = 0, cmds = 0, dones = 0;
        exp_q.delete();
        for (int i = 1; i <= 6; i++) exp_q.push_back(64'(i));
        set_req(0, 1'b1, 30'h10, 6'd5);
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            req_valid[0]   = (acks == 0);
            wdata[63:0]    = 64'(idx + 1);
            wdata_valid[0] = (idx < 6);
            #1;
            if (req_ack != 0) begin
                acks++;
                total++; if (req_ack !== 2'b01) begin bad++; $display("FAIL wr_ack got=%b want=01", req_ack); end
            end
            if (wdata_ready[0] && wdata_valid[0]) idx++;
            if (mcb_wr_en) begin
                wrs++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL wr_data extra word got=%h", mcb_wr_data); end
                else if (mcb_wr_data !== exp_q[0] || mcb_wr_mask !== 8'h00) begin bad++; $display("FAIL wr_data got=%h/%h want=%h/00", mcb_wr_data, mcb_wr_mask, exp_q[0]); void'(exp_q.pop_front()); end
                else void'(exp_q.pop_front());
            end
            if (mcb_cmd_en) begin
                cmds++;
                total++; if (mcb_cmd_instr !== 3'b000 || mcb_cmd_bl !== 6'd5 || mcb_cmd_byte_addr !== 30'h10) begin bad++; $display("FAIL wr_cmd got=%b/%0d/%h want=000/5/10", mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_byte_addr); end
                total++; if (mcb_wr_en !== 1'b0 || wrs != 6) begin bad++; $display("FAIL wr_cmd_order got wr_en=%b words=%0d want 0/6", mcb_wr_en, wrs); end
            end
            if (done != 0) begin
                dones++;
                total++; if (done !== 2'b01 || !mcb_cmd_en) begin bad++; $display("FAIL wr_done got=%b cmd_en=%b want=01/1", done, mcb_cmd_en); end
                break;
            end
        end
        total++; if (acks != 1 || wrs != 6 || cmds != 1 || dones != 1) begin bad++; $display("FAIL wr_counts got ack=%0d wr=%0d cmd=%0d done=%0d want 1/6/1/1", acks, wrs, cmds, dones); end
        drive_idle();
    endtask

    task automatic test_single_read();
        int acks = 0, cmds = 0, pops = 0, rv = 0, dones = 0, k = 0;
        bit cmd_seen = 0;
        exp_q.delete();
        mcb_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(64'h0123_4567_89AB_0000 + 64'(i));
            mcb_q.push_back(64'h0123_4567_89AB_0000 + 64'(i));
        end
        set_req(1, 1'b0, 30'h13, 6'd3);
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            req_valid[1] = (acks == 0);
            if (cmd_seen && mcb_q.size() > 0 && (k % 3) != 1) begin
                mcb_rd_empty = 1'b0;
                mcb_rd_data  = mcb_q[0];
            end else begin
                mcb_rd_empty = 1'b1;
                mcb_rd_data  = '0;
            end
            if (cmd_seen) k++;
            #1;
            if (req_ack != 0) begin
                acks++;
                total++; if (req_ack !== 2'b10) begin bad++; $display("FAIL rd_ack got=%b want=10", req_ack); end
            end
            if (mcb_cmd_en) begin
                cmds++;
                cmd_seen = 1;
                total++; if (mcb_cmd_instr !== 3'b001 || mcb_cmd_bl !== 6'd3 || mcb_cmd_byte_addr !== 30'h10) begin bad++; $display("FAIL rd_cmd got=%b/%0d/%h want=001/3/10", mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_byte_addr); end
            end
            if (mcb_rd_en) begin
                pops++;
                total++; if (mcb_rd_empty) begin bad++; $display("FAIL rd_pop_empty got rd_en=1 want=0"); end
                if (mcb_q.size() > 0) void'(mcb_q.pop_front());
            end
            if (rdata_valid != 0) begin
                rv++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL rd_data extra word got=%h", rdata); end
                else if (rdata_valid !== 2'b10 || rdata !== exp_q[0]) begin bad++; $display("FAIL rd_data got=%b/%h want=10/%h", rdata_valid, rdata, exp_q[0]); void'(exp_q.pop_front()); end
                else void'(exp_q.pop_front());
            end
            if (done != 0) begin
                dones++;
                total++; if (done !== 2'b10 || rdata_valid !== 2'b10 || rv != 4) begin bad++; $display("FAIL rd_done got=%b rv=%b words=%0d want=10/10/4", done, rdata_valid, rv); end
                break;
            end
        end
        total++; if (acks != 1 || cmds != 1 || pops != 4 || rv != 4 || dones != 1) begin bad++; $display("FAIL rd_counts got ack=%0d cmd=%0d pop=%0d rv=%0d done=%0d want 1/1/4/4/1", acks, cmds, pops, rv, dones); end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        int acks = 0, dones = 0, active = -1, wcount = 0, wword = 0, wr_total = 0;
        int rd_pending = 0, rdw = 0, rvs = 0;
        logic [1:0] want;
        set_req(0, 1'b1, 30'h100, 6'd1);
        set_req(1, 1'b0, 30'h208, 6'd0);
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            req_valid      = (acks < 4) ? 2'b11 : 2'b00;
            wdata[63:0]    = 64'h100 + 64'(wword);
            wdata_valid[0] = 1'b1;
            mcb_rd_empty   = (rd_pending == 0);
            mcb_rd_data    = 64'h200 + 64'(rdw);
            #1;
            if (req_ack != 0) begin
                want = (acks % 2 == 0) ? 2'b01 : 2'b10;
                total++; if (req_ack !== want) begin bad++; $display("FAIL b2b_ack%0d got=%b want=%b", acks, req_ack, want); end
                active = acks % 2;
                acks++;
                wcount = 0;
            end
            if (wdata_ready[0] && wdata_valid[0]) wword++;
            if (mcb_wr_en) begin
                wcount++;
                total++; if (active != 0 || mcb_wr_data !== 64'h100 + 64'(wr_total)) begin bad++; $display("FAIL b2b_wr got owner=%0d data=%h want owner=0 data=%h", active, mcb_wr_data, 64'h100 + 64'(wr_total)); end
                wr_total++;
            end
            if (mcb_rd_en) begin
                total++; if (active != 1) begin bad++; $display("FAIL b2b_rd_owner got=%0d want=1", active); end
                rd_pending--;
                rdw++;
            end
            if (mcb_cmd_en) begin
                total++;
                if (active == 1) begin
                    if (mcb_cmd_instr !== 3'b001 || mcb_cmd_byte_addr !== 30'h208) begin bad++; $display("FAIL b2b_rd_cmd got=%b/%h want=001/208", mcb_cmd_instr, mcb_cmd_byte_addr); end
                    rd_pending = 1;
                end else begin
                    if (mcb_cmd_instr !== 3'b000 || wcount != 2 || mcb_cmd_byte_addr !== 30'h100) begin bad++; $display("FAIL b2b_wr_cmd got=%b/%h words=%0d want=000/100/2", mcb_cmd_instr, mcb_cmd_byte_addr, wcount); end
                end
            end
            if (rdata_valid != 0) begin
                total++; if (rdata_valid !== 2'b10 || rdata !== 64'h200 + 64'(rvs)) begin bad++; $display("FAIL b2b_rdata got=%b/%h want=10/%h", rdata_valid, rdata, 64'h200 + 64'(rvs)); end
                rvs++;
            end
            if (done != 0) begin
                want = (active == 0) ? 2'b01 : 2'b10;
                total++; if (done !== want) begin bad++; $display("FAIL b2b_done%0d got=%b want=%b", dones, done, want); end
                dones++;
                if (dones == 4) break;
            end
        end
        total++; if (acks != 4 || dones != 4 || wr_total != 4 || rvs != 2) begin bad++; $display("FAIL b2b_counts got ack=%0d done=%0d wr=%0d rd=%0d want 4/4/4/2", acks, dones, wr_total, rvs); end
        drive_idle();
    endtask

    task automatic test_stall();
        int idx = 0, acks = 0, ac = 0, cf = -1, wrs = 0, cmds = 0, dones = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(64'h5000 + 64'(i));
        set_req(0, 1'b1, 30'h47, 6'd7);
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            req_valid[0]   = (acks == 0);
            if (acks > 0) ac++;
            mcb_wr_full    = (ac >= 3 && ac <= 7);
            mcb_cmd_full   = (cf != 0);
            if (cf > 0) cf--;
            wdata[63:0]    = 64'h5000 + 64'(idx);
            wdata_valid[0] = (idx < 8);
            #1;
            if (req_ack != 0) acks++;
            if (mcb_wr_full) begin
                total++; if (wdata_ready !== 2'b00) begin bad++; $display("FAIL stall_wready got=%b want=00", wdata_ready); end
            end
            if (wdata_ready[0] && wdata_valid[0]) begin
                idx++;
                if (idx == 8) cf = 3;
            end
            if (mcb_wr_en) begin
                wrs++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL stall_wr extra word got=%h", mcb_wr_data); end
                else if (mcb_wr_data !== exp_q[0]) begin bad++; $display("FAIL stall_wr got=%h want=%h", mcb_wr_data, exp_q[0]); void'(exp_q.pop_front()); end
                else void'(exp_q.pop_front());
            end
            if (mcb_cmd_en) begin
                cmds++;
                total++; if (mcb_cmd_full || mcb_cmd_bl !== 6'd7 || mcb_cmd_byte_addr !== 30'h40) begin bad++; $display("FAIL stall_cmd got full=%b bl=%0d addr=%h want 0/7/40", mcb_cmd_full, mcb_cmd_bl, mcb_cmd_byte_addr); end
            end
            if (done != 0) begin
                dones++;
                break;
            end
        end
        total++; if (wrs != 8 || cmds != 1 || dones != 1 || exp_q.size() != 0) begin bad++; $display("FAIL stall_counts got wr=%0d cmd=%0d done=%0d left=%0d want 8/1/1/0", wrs, cmds, dones, exp_q.size()); end
        drive_idle();
    endtask

    task automatic test_calib();
        int dones = 0, wrs = 0;
        calib_done = 1'b0;
        set_req(1, 1'b1, 30'h88, 6'd0);
        wdata[127:64]  = 64'h55;
        wdata_valid[1] = 1'b1;
        req_valid[1]   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            total++; if (req_ack !== 2'b00 || dbg_state !== 3'd0) begin bad++; $display("FAIL calib_hold got ack=%b state=%0d want 00/0", req_ack, dbg_state); end
        end
        @(negedge clk);
        calib_done = 1'b1;
        @(negedge clk);
        #1;
        total++; if (req_ack !== 2'b10) begin bad++; $display("FAIL calib_ack got=%b want=10", req_ack); end
        // calibration loss during the burst must not stop it
        calib_done   = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            req_valid = 2'b00;
            #1;
            if (mcb_wr_en) begin
                wrs++;
                total++; if (mcb_wr_data !== 64'h55) begin bad++; $display("FAIL calib_wr got=%h want=55", mcb_wr_data); end
            end
            if (done != 0) begin
                dones++;
                total++; if (done !== 2'b10 || mcb_cmd_byte_addr !== 30'h88) begin bad++; $display("FAIL calib_done got=%b/%h want=10/88", done, mcb_cmd_byte_addr); end
                break;
            end
        end
        total++; if (wrs != 1 || dones != 1) begin bad++; $display("FAIL calib_counts got wr=%0d done=%0d want 1/1", wrs, dones); end
        calib_done = 1'b1;
        drive_idle();
    endtask

    task automatic test_reset_mid();
        int acks = 0, rv = 0, dones = 0;
        bit cmd_seen = 0;
        set_req(0, 1'b0, 30'h300, 6'd7);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            req_valid[0] = (acks == 0);
            mcb_rd_empty = !cmd_seen;
            mcb_rd_data  = 64'h7700 + 64'(cyc);
            #1;
            if (req_ack != 0) acks++;
            if (mcb_cmd_en) cmd_seen = 1;
            if (rdata_valid != 0) rv++;
            if (rv == 3) break;
        end
        total++; if (rv != 3) begin bad++; $display("FAIL rstmid_pre got words=%0d want=3", rv); end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++; if ({req_ack, wdata_ready, rdata_valid, done} !== 8'h00 || rdata !== 64'd0) begin bad++; $display("FAIL rstmid_req_side got=%b/%h want=0/0", {req_ack, wdata_ready, rdata_valid, done}, rdata); end
        total++; if ({mcb_cmd_en, mcb_wr_en, mcb_rd_en} !== 3'b000 || dbg_state !== 3'd0) begin bad++; $display("FAIL rstmid_mcb_side got=%b state=%0d want=000/0", {mcb_cmd_en, mcb_wr_en, mcb_rd_en}, dbg_state); end
        @(negedge clk);
        drive_idle();
        reset_n = 1'b1;
        set_req(0, 1'b1, 30'h20, 6'd0);
        wdata[63:0]    = 64'h99;
        wdata_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b1;
        @(negedge clk);
        #1;
        total++; if (req_ack !== 2'b01) begin bad++; $display("FAIL rstmid_ack got=%b want=01", req_ack); end
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            req_valid = 2'b00;
            #1;
            if (done != 0) begin
                dones++;
                total++; if (done !== 2'b01 || mcb_cmd_byte_addr !== 30'h20) begin bad++; $display("FAIL rstmid_done got=%b/%h want=01/20", done, mcb_cmd_byte_addr); end
                break;
            end
        end
        total++; if (dones != 1) begin bad++; $display("FAIL rstmid_complete got=%0d want=1", dones); end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_stall();
        test_calib();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
